// File: rtl/serial_logic_unit_pkg.sv
// Shared types for the serial logic unit: opcode and FSM state encodings.
package slu_pkg;

   typedef enum logic [2:0] {
      OP_NOT  = 3'b000,
      OP_AND  = 3'b001,
      OP_OR   = 3'b010,
      OP_XOR  = 3'b011,
      OP_XNOR = 3'b100,
      OP_NAND = 3'b101,
      OP_NOR  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Step counter width; never narrower than one bit so NSTEP=1 still works.
   function automatic int cnt_w(input int nstep);
      return (nstep > 1) ? $clog2(nstep) : 1;
   endfunction

endpackage

// File: rtl/serial_logic_unit_if.sv
// Operand/result handshake bundle for serial_logic_unit.
interface serial_logic_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_parity;
   logic             out_zero;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_parity, out_zero, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_parity, out_zero, busy
   );
endinterface

// File: rtl/serial_logic_unit_slice.sv
// Combinational W-bit gate: applies one of the eight bitwise ops to a and b.
module slu_slice
   import slu_pkg::*;
#(
   parameter int W = 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  op_e          op_i,
   output logic [W-1:0] y_o
);

   always_comb begin
      y_o = a_i;
      case (op_i)
         OP_NOT:  y_o = ~a_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_XNOR: y_o = ~(a_i ^ b_i);
         OP_NAND: y_o = ~(a_i & b_i);
         OP_NOR:  y_o = ~(a_i | b_i);
         default: y_o = a_i;
      endcase
   end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: processes WIDTH-bit operands SLICE bits per cycle,
// LSB first, with running parity/zero flags and valid/ready on both sides.
module serial_logic_unit
   import slu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input logic               clk,
   input logic               rst_n,
   serial_logic_unit_if.slave bus
);

   localparam int NSTEP = WIDTH / SLICE;
   localparam int CW    = cnt_w(NSTEP);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_acc_q, par_acc_d, zero_acc_q, zero_acc_d;
   logic             par_q, par_d, zero_q, zero_d;
   logic [SLICE-1:0] y;

   slu_slice #(.W(SLICE)) u_slice (
      .a_i (a_q[SLICE-1:0]),
      .b_i (b_q[SLICE-1:0]),
      .op_i(op_q),
      .y_o (y)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      sh_d       = sh_q;
      res_d      = res_q;
      cnt_d      = cnt_q;
      par_acc_d  = par_acc_q;
      zero_acc_d = zero_acc_q;
      par_d      = par_q;
      zero_d     = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.in_a;
               b_d        = bus.in_b;
               op_d       = op_e'(bus.in_op);
               cnt_d      = '0;
               par_acc_d  = 1'b0;
               zero_acc_d = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            a_d        = a_q >> SLICE;
            b_d        = b_q >> SLICE;
            // New bits enter at the top so the LSB-first result lands aligned.
            sh_d       = (sh_q >> SLICE) | (WIDTH'(y) << (WIDTH - SLICE));
            par_acc_d  = par_acc_q ^ (^y);
            zero_acc_d = zero_acc_q & ~(|y);
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CW'(NSTEP - 1)) begin
               res_d   = sh_d;
               par_d   = par_acc_d;
               zero_d  = zero_acc_d;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= OP_NOT;
         a_q        <= '0;
         b_q        <= '0;
         sh_q       <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         par_acc_q  <= 1'b0;
         zero_acc_q <= 1'b0;
         par_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sh_q       <= sh_d;
         res_q      <= res_d;
         cnt_q      <= cnt_d;
         par_acc_q  <= par_acc_d;
         zero_acc_q <= zero_acc_d;
         par_q      <= par_d;
         zero_q     <= zero_d;
      end
   end

   // All outputs come from registers only.
   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.out_result = res_q;
   assign bus.out_parity = par_q;
   assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench: SLICE=1 and SLICE=4 instances, table vectors, op sweep,
// backpressure and mid-operation reset, with a result scoreboard per instance.
`timescale 1ns/1ps
module tb_serial_logic_unit;

   typedef struct {
      logic [7:0] res;
      logic       par;
      logic       zero;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] res;
      logic       par;
      logic       zero;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   serial_logic_unit_if #(.WIDTH(8)) b1 ();
   serial_logic_unit_if #(.WIDTH(8)) b4 ();

   serial_logic_unit #(.WIDTH(8), .SLICE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   serial_logic_unit #(.WIDTH(8), .SLICE(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endfunction

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      exp_t e;
      logic [7:0] r;
      case (op)
         3'd0: r = ~a;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: r = ~(a ^ b);
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a;
      endcase
      e.res  = r;
      e.par  = ^r;
      e.zero = (r == 8'h00);
      return e;
   endfunction

   function automatic logic rdy(input int sel);
      return (sel == 0) ? b1.in_ready : b4.in_ready;
   endfunction

   function automatic logic ov(input int sel);
      return (sel == 0) ? b1.out_valid : b4.out_valid;
   endfunction

   task automatic set_in(input int sel, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
      if (sel == 0) begin
         b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_op = op;
      end else begin
         b4.in_valid = v; b4.in_a = a; b4.in_b = b; b4.in_op = op;
      end
   endtask

   // Entered and left just after a rising edge; returns once out_valid is seen.
   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input exp_t e);
      int n;
      int ns;
      ns = (sel == 0) ? 8 : 2;
      n = 0;
      while (!rdy(sel) && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_ready", 32'(rdy(sel)), 32'd1);
      set_in(sel, 1'b1, a, b, op);
      if (sel == 0) q1.push_back(e); else q4.push_back(e);
      @(posedge clk); #1;
      set_in(sel, 1'b0, a, b, op);
      n = 0;
      while (!ov(sel) && n < 50) begin @(posedge clk); #1; n++; end
      chk(sel == 0 ? "latency_s1" : "latency_s4", 32'(n), 32'(ns));
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst_n && b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) chk("sb1_unexpected", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            chk("s1_result", 32'(b1.out_result), 32'(e.res));
            chk("s1_parity", 32'(b1.out_parity), 32'(e.par));
            chk("s1_zero",   32'(b1.out_zero),   32'(e.zero));
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (rst_n && b4.out_valid && b4.out_ready) begin
         if (q4.size() == 0) chk("sb4_unexpected", 32'd1, 32'd0);
         else begin
            e = q4.pop_front();
            chk("s4_result", 32'(b4.out_result), 32'(e.res));
            chk("s4_parity", 32'(b4.out_parity), 32'(e.par));
            chk("s4_zero",   32'(b4.out_zero),   32'(e.zero));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : stim
      vec_t vt[6];
      exp_t e;
      logic [7:0] ra, rb;
      vt[0] = '{a:8'hA5, b:8'h3C, op:3'b011, res:8'h99, par:1'b0, zero:1'b0};
      vt[1] = '{a:8'hA5, b:8'h3C, op:3'b100, res:8'h66, par:1'b0, zero:1'b0};
      vt[2] = '{a:8'h0F, b:8'hF0, op:3'b001, res:8'h00, par:1'b0, zero:1'b1};
      vt[3] = '{a:8'h5A, b:8'hFF, op:3'b000, res:8'hA5, par:1'b0, zero:1'b0};
      vt[4] = '{a:8'h5A, b:8'hFF, op:3'b111, res:8'h5A, par:1'b0, zero:1'b0};
      vt[5] = '{a:8'h01, b:8'hFF, op:3'b111, res:8'h01, par:1'b1, zero:1'b0};

      set_in(0, 1'b0, 8'h00, 8'h00, 3'd0);
      set_in(1, 1'b0, 8'h00, 8'h00, 3'd0);
      b1.out_ready = 1'b1;
      b4.out_ready = 1'b1;
      #12;
      chk("rst_in_ready",  32'(b1.in_ready),   32'd1);
      chk("rst_out_valid", 32'(b1.out_valid),  32'd0);
      chk("rst_busy",      32'(b1.busy),       32'd0);
      chk("rst_result",    32'(b1.out_result), 32'd0);
      chk("rst_parity",    32'(b1.out_parity), 32'd0);
      chk("rst_zero",      32'(b1.out_zero),   32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         e.res = vt[i].res; e.par = vt[i].par; e.zero = vt[i].zero;
         run_op(0, vt[i].a, vt[i].b, vt[i].op, e);
      end

      e.res = 8'h55; e.par = 1'b0; e.zero = 1'b0;
      run_op(1, 8'hC3, 8'h96, 3'b011, e);

      for (int op = 0; op < 8; op++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         run_op(0, ra, rb, 3'(op), model(ra, rb, 3'(op)));
         run_op(1, ra, rb, 3'(op), model(ra, rb, 3'(op)));
      end
      @(posedge clk); #1;

      // Backpressure: result must hold and stray in_valid must be dropped.
      b1.out_ready = 1'b0;
      e.res = 8'h83; e.par = 1'b1; e.zero = 1'b0;
      run_op(0, 8'h81, 8'h02, 3'b010, e);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(b1.out_valid),  32'd1);
         chk("bp_result",    32'(b1.out_result), 32'h83);
         chk("bp_parity",    32'(b1.out_parity), 32'd1);
         chk("bp_in_ready",  32'(b1.in_ready),   32'd0);
         set_in(0, (i % 2) == 0, 8'hFF, 8'hFF, 3'b111);
         @(posedge clk); #1;
      end
      set_in(0, 1'b0, 8'h00, 8'h00, 3'd0);
      b1.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_after", 32'(b1.in_ready),  32'd1);
      chk("bp_valid_after", 32'(b1.out_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_capture_busy", 32'(b1.busy),       32'd0);
      chk("bp_result_held",     32'(b1.out_result), 32'h83);

      // Asynchronous reset three cycles into RUN.
      set_in(0, 1'b1, 8'hFF, 8'hFF, 3'b001);
      @(posedge clk); #1;
      set_in(0, 1'b0, 8'h00, 8'h00, 3'd0);
      repeat (3) @(posedge clk);
      #3;
      chk("mid_run_busy", 32'(b1.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready",  32'(b1.in_ready),   32'd1);
      chk("arst_out_valid", 32'(b1.out_valid),  32'd0);
      chk("arst_busy",      32'(b1.busy),       32'd0);
      chk("arst_result",    32'(b1.out_result), 32'd0);
      chk("arst_parity",    32'(b1.out_parity), 32'd0);
      chk("arst_zero",      32'(b1.out_zero),   32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      e.res = 8'h00; e.par = 1'b0; e.zero = 1'b1;
      run_op(0, 8'hFF, 8'hFF, 3'b101, e);

      repeat (4) @(posedge clk);
      #1;
      chk("sb1_drained", 32'(q1.size()), 32'd0);
      chk("sb4_drained", 32'(q4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Parametrised, multi-operation bitwise logic unit that processes WIDTH-bit operands SLICE bits per clock.
- Generalises the team's fixed 1-bit gate library (NOT/AND/OR/XOR/XNOR) to N bits and eight selectable operations.
- Adds valid/ready handshakes, a small FSM, and running parity and zero flags.
- Sits between a register-file read port and a result bus where area matters more than throughput.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be ≥ 2 and an integer multiple of SLICE.
- SLICE, 1: bits processed per RUN cycle. Legal values divide WIDTH.
- NSTEP, WIDTH/SLICE: derived localparam; number of RUN cycles.

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  unit can accept an operation
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for NOT/PASS)
- in_op  in  3  operation select
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result word
- out_parity  out  1  XOR-reduction of out_result
- out_zero  out  1  1 when out_result == 0
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Opcodes:
  - 000 NOT A
  - 001 AND
  - 010 OR
  - 011 XOR
  - 100 XNOR
  - 101 NAND
  - 110 NOR
  - 111 PASS A
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, out_parity=0, out_zero=0, step counter=0, shift registers=0. Assertion mid-operation aborts it and discards all data.
- FSM: IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_a, in_b and in_op into shift registers and op register; clear counter and parity accumulator; set zero accumulator to 1; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, apply op to the SLICE LSBs of the A/B shift registers.
  - Shift both operand registers right by SLICE.
  - Shift the SLICE result bits into the MSB end of the result register (LSB-first processing, so after NSTEP cycles the result is correctly aligned).
  - Update the accumulators: parity ^= ^slice_result; zero &= (slice_result == 0).
  - Counter increments each cycle. When counter == NSTEP-1, go to DONE on that edge.
- DONE:
  - out_valid=1. out_result, out_parity and out_zero are registered and held stable until the handshake.
  - On out_ready: go to IDLE and drop out_valid on that edge.
  - out_result keeps its value after the handshake until the next DONE.
- Latency: acceptance on edge E0 gives out_valid high after edge E0+NSTEP.
- Throughput: at most one operation per NSTEP+2 cycles with out_ready tied high. There is no accept in the handshake cycle.
- Illegal input: in_valid while in RUN or DONE is ignored, and the input is neither latched nor queued. Inputs may change freely while in_ready=0.
- out_ready while out_valid=0 has no effect.
- Counter width is clog2(NSTEP), minimum 1 bit. NSTEP=1 (SLICE=WIDTH) is legal: RUN lasts exactly one cycle.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Decomposition:
- Package slu_pkg holds:
  - the op_e enum with the 3-bit codes above;
  - the state_e enum (IDLE, RUN, DONE).
- Sub-module slu_slice: purely combinational SLICE-wide operation (a, b, op → y). It is instantiated once in the datapath and is reusable elsewhere as the parametrised gate library.

Test Plan:
- XOR, WIDTH=8, SLICE=1: a=8'hA5, b=8'h3C, op=011 → out_valid exactly 8 cycles after accept, result=8'h99, parity=0, zero=0.
- XNOR: same operands, op=100 → result=8'h66, parity=0, zero=0. AND: a=8'h0F, b=8'hF0, op=001 → result=8'h00, zero=1, parity=0.
- NOT and PASS: a=8'h5A, b=8'hFF.
  - op=000 → result=8'hA5, parity=0.
  - op=111 → result=8'h5A.
  - a=8'h01, op=111 → parity=1.
- Backpressure: complete an OR of 8'h81 and 8'h02, hold out_ready=0 for 5 cycles while pulsing in_valid.
  - Result holds 8'h83, parity=1, and in_ready stays 0 throughout.
  - After the out_ready pulse, in_ready=1 the next cycle, and the extra in_valid was not captured.
- Reset mid-RUN: accept an op, assert rst_n=0 after 3 RUN cycles → in_ready=1 and all outputs zero asynchronously. After release, a new NAND of 8'hFF and 8'hFF gives result=8'h00 after 8 cycles.
- Parallel slice, WIDTH=8, SLICE=4: a=8'hC3, b=8'h96, XOR → result=8'h55 with out_valid 2 cycles after accept. Also sweep all 8 ops against a reference model.
